square_game_engine: RTL

//  Parametrised game core for the square game. Holds square position and game state,

---
 rtl/square_game_engine.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/square_game_engine.sv
// Square game core: position, motion tick, game FSM and pixel render.
// One registered RGB pixel per clock from the sync generator's coordinates.
module square_game_engine #(
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int SQ_SIZE   = 18,
  parameter int HOLE_X    = 300,
  parameter int HOLE_Y    = 198,
  parameter int HOLE_SIZE = 20,
  parameter int START_X   = 0,
  parameter int START_Y   = 200,
  parameter int TICK_DIV  = 310000,
  parameter int STEP      = 1,
  parameter int EDGE_MODE = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] x_px,
  input  logic [9:0] y_px,
  input  logic       activevideo,
  input  logic       btn_up,
  input  logic       btn_dn,
  input  logic       btn_lt,
  input  logic       btn_rt,
  input  logic       start,
  output logic [9:0] sq_x,
  output logic [9:0] sq_y,
  output logic [1:0] state,
  output logic       win,
  output logic [3:0] pix_r,
  output logic [3:0] pix_g,
  output logic [3:0] pix_b
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [10:0] X_MAX  = 11'(H_RES - SQ_SIZE);
  localparam logic [10:0] Y_MAX  = 11'(V_RES - SQ_SIZE);
  localparam logic [10:0] STP    = 11'(STEP);
  localparam logic [10:0] SQ     = 11'(SQ_SIZE);
  localparam logic [10:0] HX0    = 11'(HOLE_X);
  localparam logic [10:0] HY0    = 11'(HOLE_Y);
  localparam logic [10:0] HX1    = 11'(HOLE_X + HOLE_SIZE);
  localparam logic [10:0] HY1    = 11'(HOLE_Y + HOLE_SIZE);
  localparam logic [10:0] IX0    = 11'(HOLE_X + 2);
  localparam logic [10:0] IY0    = 11'(HOLE_Y + 2);
  localparam logic [10:0] IX1    = 11'(HOLE_X + HOLE_SIZE - 2);
  localparam logic [10:0] IY1    = 11'(HOLE_Y + HOLE_SIZE - 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WIN  = 2'd2
  } st_t;

  typedef enum logic [1:0] {
    D_UP = 2'd0,
    D_DN = 2'd1,
    D_LT = 2'd2,
    D_RT = 2'd3
  } dir_t;

  st_t         st;
  dir_t        dir;
  dir_t        dir_s;
  dir_t        ndir;
  logic [CW-1:0] cnt;
  logic        tick;
  logic [9:0]  nx;
  logic [9:0]  ny;
  logic [10:0] x_w;
  logic [10:0] y_w;
  logic [10:0] x_inc;
  logic [10:0] y_inc;
  logic        hit;
  logic [10:0] px_w;
  logic [10:0] py_w;
  logic        in_sq;
  logic        in_hole;
  logic        in_inner;

  assign state = st;
  assign tick  = (cnt == CW'(TICK_DIV - 1));
  assign x_w   = {1'b0, sq_x};
  assign y_w   = {1'b0, sq_y};
  assign x_inc = x_w + STP;
  assign y_inc = y_w + STP;
  assign px_w  = {1'b0, x_px};
  assign py_w  = {1'b0, y_px};

  // Free-running motion tick divider.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Button sample with up > down > left > right priority.
  always_comb begin
    dir_s = dir;
    priority case (1'b1)
      btn_up:  dir_s = D_UP;
      btn_dn:  dir_s = D_DN;
      btn_lt:  dir_s = D_LT;
      btn_rt:  dir_s = D_RT;
      default: dir_s = dir;
    endcase
  end

  // Next position along the sampled axis, with wrap or bounce at edges.
  always_comb begin
    nx   = sq_x;
    ny   = sq_y;
    ndir = dir_s;
    case (dir_s)
      D_RT: begin
        if (x_inc > X_MAX) begin
          if (EDGE_MODE == 0) begin
            nx = '0;
          end else begin
            nx   = X_MAX[9:0];
            ndir = D_LT;
          end
        end else begin
          nx = x_inc[9:0];
        end
      end
      D_LT: begin
        if (x_w < STP) begin
          if (EDGE_MODE == 0) begin
            nx = X_MAX[9:0];
          end else begin
            nx   = '0;
            ndir = D_RT;
          end
        end else begin
          nx = sq_x - STP[9:0];
        end
      end
      D_DN: begin
        if (y_inc > Y_MAX) begin
          if (EDGE_MODE == 0) begin
            ny = '0;
          end else begin
            ny   = Y_MAX[9:0];
            ndir = D_UP;
          end
        end else begin
          ny = y_inc[9:0];
        end
      end
      default: begin
        if (y_w < STP) begin
          if (EDGE_MODE == 0) begin
            ny = Y_MAX[9:0];
          end else begin
            ny   = '0;
            ndir = D_DN;
          end
        end else begin
          ny = sq_y - STP[9:0];
        end
      end
    endcase
  end

  // Square fully inside the hole, from the registered position.
  assign hit = (x_w >= HX0) && (x_w + SQ <= HX1) &&
               (y_w >= HY0) && (y_w + SQ <= HY1);

  // Game FSM: start, motion on tick, win on hit, position frozen in WIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st   <= S_IDLE;
      sq_x <= 10'(START_X);
      sq_y <= 10'(START_Y);
      dir  <= D_RT;
      win  <= 1'b0;
    end else begin
      case (st)
        S_IDLE: begin
          if (start) begin
            st   <= S_RUN;
            sq_x <= 10'(START_X);
            sq_y <= 10'(START_Y);
            dir  <= D_RT;
          end
        end
        S_RUN: begin
          if (hit) begin
            st  <= S_WIN;
            win <= 1'b1;
          end else if (tick) begin
            sq_x <= nx;
            sq_y <= ny;
            dir  <= ndir;
          end
        end
        S_WIN: begin
          if (start) begin
            st  <= S_IDLE;
            win <= 1'b0;
          end
        end
        default: begin
          st  <= S_IDLE;
          win <= 1'b0;
        end
      endcase
    end
  end

  assign in_sq = (px_w >= x_w) && (px_w < x_w + SQ) &&
                 (py_w >= y_w) && (py_w < y_w + SQ);

  assign in_hole = (px_w >= HX0) && (px_w < HX1) &&
                   (py_w >= HY0) && (py_w < HY1);

  assign in_inner = (px_w >= IX0) && (px_w < IX1) &&
                    (py_w >= IY0) && (py_w < IY1);

  // Pixel colour: square over hole ring over black; blank outside video.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_r <= '0;
      pix_g <= '0;
      pix_b <= '0;
    end else begin
      pix_b <= '0;
      if (!activevideo) begin
        pix_r <= '0;
        pix_g <= '0;
      end else if (in_sq) begin
        pix_r <= 4'd8;
        pix_g <= (st == S_WIN) ? 4'd8 : 4'd0;
      end else if (in_hole && !in_inner) begin
        pix_r <= '0;
        pix_g <= 4'd8;
      end else begin
        pix_r <= '0;
        pix_g <= '0;
      end
    end
  end

endmodule
